// File: rtl/sram_test_pkg.sv
// Shared types, failure codes and the march data pattern for the SRAM march tester.
package sram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_ISSUE,
        ST_WAIT_XFER,
        ST_CHECK,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } march_state_t;

    localparam logic [1:0] FAIL_NONE     = 2'b00;
    localparam logic [1:0] FAIL_MISMATCH = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAIL_RANGE    = 2'b11;

    // Wide enough for any practical word/address width; callers size-cast the result.
    localparam int PAT_W = 64;

    function automatic logic [PAT_W-1:0] march_pattern(input logic [PAT_W-1:0] addr,
                                                       input logic [PAT_W-1:0] seed,
                                                       input logic             invert);
        logic [PAT_W-1:0] p;
        p = addr ^ seed;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/sram_req_handshake.sv
// Request/busy handshake toward the SPI SRAM encoder, with per-transaction timeout.
module sram_req_handshake #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic busy,
    output logic request,
    output logic complete,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             saw_busy;
    logic [CNT_W-1:0] count;

    // Handshake: launch raises request on the next edge; request then holds until the
    // first cycle where busy is low after having been seen high (complete), or until
    // TIMEOUT_CYCLES request-high cycles elapse (timeout). request drops on the edge
    // after either pulse; both pulses are only ever asserted while request is high.
    assign complete = request && saw_busy && !busy;
    assign timeout  = request && !complete && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            request  <= 1'b0;
            saw_busy <= 1'b0;
            count    <= '0;
        end else if (launch) begin
            request  <= 1'b1;
            saw_busy <= 1'b0;
            count    <= '0;
        end else if (request) begin
            if (complete || timeout) request <= 1'b0;
            if (busy) saw_busy <= 1'b1;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_march_tester.sv
// Four-phase march test sequencer (write P up, read P up, write ~P down, read ~P down)
// driving the SPI SRAM encoder; stops on the first failure and keeps diagnostics.
module sram_march_tester
    import sram_test_pkg::*;
#(
    parameter int                    WORD_WIDTH     = 16,
    parameter int                    ADDRESS_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] SEED           = WORD_WIDTH'(16'hA5C3),
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] addr_lo,
    input  logic [ADDRESS_WIDTH-1:0] addr_hi,
    output logic                     running,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic [1:0]               phase,
    output logic [ADDRESS_WIDTH-1:0] err_address,
    output logic [WORD_WIDTH-1:0]    err_expected,
    output logic [WORD_WIDTH-1:0]    err_actual,
    output logic                     request,
    input  logic                     busy,
    input  logic                     initialized,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     write_enable,
    output logic [WORD_WIDTH-1:0]    data_out,
    input  logic [WORD_WIDTH-1:0]    data_in,
    output march_state_t             state_dbg
);

    march_state_t              state;
    logic [ADDRESS_WIDTH-1:0]  lo_q;
    logic [ADDRESS_WIDTH-1:0]  hi_q;
    logic [WORD_WIDTH-1:0]     rdata;
    logic [WORD_WIDTH-1:0]     expected;
    logic                      complete;
    logic                      timeout;

    assign state_dbg = state;

    // Phases 2 and 3 work on the inverted pattern.
    assign expected = WORD_WIDTH'(march_pattern(PAT_W'(address), PAT_W'(SEED), phase[1]));

    sram_req_handshake #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_handshake (
        .clk     (clk),
        .reset   (reset),
        .launch  (state == ST_ISSUE),
        .busy    (busy),
        .request (request),
        .complete(complete),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= FAIL_NONE;
            phase        <= 2'd0;
            address      <= '0;
            write_enable <= 1'b0;
            data_out     <= '0;
            err_address  <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            rdata        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        lo_q         <= addr_lo;
                        hi_q         <= addr_hi;
                        fail_code    <= FAIL_NONE;
                        err_address  <= '0;
                        err_expected <= '0;
                        err_actual   <= '0;
                        pass         <= 1'b0;
                        if (addr_lo > addr_hi) begin
                            fail_code <= FAIL_RANGE;
                            done      <= 1'b1;
                            running   <= 1'b0;
                            state     <= ST_FAIL;
                        end else begin
                            done    <= 1'b0;
                            running <= 1'b1;
                            phase   <= 2'd0;
                            address <= addr_lo;
                            state   <= ST_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT_INIT: begin
                    if (initialized && !busy) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    write_enable <= !phase[0];
                    data_out     <= expected;
                    state        <= ST_WAIT_XFER;
                end
                ST_WAIT_XFER: begin
                    if (complete) begin
                        if (phase[0]) begin
                            rdata <= data_in;
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end else if (timeout) begin
                        fail_code   <= FAIL_TIMEOUT;
                        err_address <= address;
                        done        <= 1'b1;
                        running     <= 1'b0;
                        state       <= ST_FAIL;
                    end
                end
                ST_CHECK: begin
                    if (rdata != expected) begin
                        fail_code    <= FAIL_MISMATCH;
                        err_address  <= address;
                        err_expected <= expected;
                        err_actual   <= rdata;
                        done         <= 1'b1;
                        running      <= 1'b0;
                        state        <= ST_FAIL;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // End-of-range test happens before stepping, so the address never wraps.
                    state <= ST_ISSUE;
                    if (!phase[1]) begin
                        if (address == hi_q) begin
                            phase   <= phase + 2'd1;
                            address <= phase[0] ? hi_q : lo_q;
                        end else begin
                            address <= address + ADDRESS_WIDTH'(1);
                        end
                    end else begin
                        if (address == lo_q) begin
                            if (phase[0]) begin
                                pass    <= 1'b1;
                                done    <= 1'b1;
                                running <= 1'b0;
                                state   <= ST_DONE;
                            end else begin
                                phase   <= 2'd3;
                                address <= hi_q;
                            end
                        end else begin
                            address <= address - ADDRESS_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester: behavioural encoder plus an abstract march model/scoreboard.
module tb_sram_march_tester;
    import sram_test_pkg::*;

    localparam int W = 33;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  addr_lo, addr_hi;
    logic         running, done, pass;
    logic [1:0]   fail_code, phase;
    logic [15:0]  err_address, err_expected, err_actual;
    logic         request, busy, initialized;
    logic [15:0]  address;
    logic         write_enable;
    logic [15:0]  data_out, data_in;
    march_state_t state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    sram_march_tester #(
        .WORD_WIDTH    (16),
        .ADDRESS_WIDTH (16),
        .SEED          (16'hA5C3),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr_lo     (addr_lo),
        .addr_hi     (addr_hi),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .phase       (phase),
        .err_address (err_address),
        .err_expected(err_expected),
        .err_actual  (err_actual),
        .request     (request),
        .busy        (busy),
        .initialized (initialized),
        .address     (address),
        .write_enable(write_enable),
        .data_out    (data_out),
        .data_in     (data_in),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural encoder ----------------
    logic [15:0] mem [0:65535];
    bit          hang = 0;
    bit          stuck = 0;
    int          busy_cnt, init_cnt;
    bit          need_low;

    always @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            busy_cnt    <= 0;
            need_low    <= 1'b0;
            init_cnt    <= 0;
            initialized <= 1'b0;
        end else begin
            if (init_cnt < 100) init_cnt <= init_cnt + 1;
            if (init_cnt == 99) initialized <= 1'b1;
            if (!request) need_low <= 1'b0;
            if (busy) begin
                if (busy_cnt == 1) busy <= 1'b0;
                busy_cnt <= busy_cnt - 1;
            end else if (request && !need_low && !hang) begin
                busy     <= 1'b1;
                busy_cnt <= 20;
                need_low <= 1'b1;
                if (write_enable) mem[address] <= data_out;
                else data_in <= mem[address] | ((stuck && address == 16'h0012) ? 16'h0008 : 16'h0000);
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- march model ----------------
    logic [W-1:0] exp_q[$];
    bit           exp_pass;
    logic [1:0]   exp_code, exp_phase;
    logic [15:0]  exp_err_a, exp_err_e, exp_err_x, exp_addr;
    int           exp_txn;

    function automatic logic [15:0] pat(input logic [15:0] a, input bit inv);
        return (a ^ 16'hA5C3) ^ (inv ? 16'hFFFF : 16'h0000);
    endfunction

    task automatic build_model(input logic [15:0] lo, input logic [15:0] hi, input bit h, input bit s);
        logic [15:0] mm [int];
        logic [15:0] a, d, rd;
        int          n;
        bit          stop;
        exp_q.delete();
        exp_pass = 0; exp_code = 2'd0; exp_phase = 2'd0; exp_addr = lo;
        exp_err_a = '0; exp_err_e = '0; exp_err_x = '0; exp_txn = 0;
        if (lo > hi) begin
            exp_code = 2'd3;
            return;
        end
        n = int'(hi) - int'(lo) + 1;
        stop = 0;
        for (int ph = 0; ph < 4 && !stop; ph++) begin
            for (int k = 0; k < n && !stop; k++) begin
                a = (ph < 2) ? 16'(int'(lo) + k) : 16'(int'(hi) - k);
                d = pat(a, ph >= 2);
                exp_q.push_back({(ph % 2) == 0, a, d});
                exp_txn++;
                exp_phase = 2'(ph);
                exp_addr  = a;
                if (h) begin
                    exp_code = 2'd2; exp_err_a = a; stop = 1;
                end else if (ph % 2 == 0) begin
                    mm[int'(a)] = d;
                end else begin
                    rd = mm[int'(a)] | ((s && a == 16'h0012) ? 16'h0008 : 16'h0000);
                    if (rd != d) begin
                        exp_code = 2'd1; exp_err_a = a; exp_err_e = d; exp_err_x = rd; stop = 1;
                    end
                end
            end
        end
        if (!stop) exp_pass = 1;
    endtask

    // ---------------- scoreboard / per-cycle compare ----------------
    logic [W-1:0] cur;
    bit  prev_req, prev_busy, expect_fall, have_prev, prev_we;
    int  low_cnt, hi_len, last_hi_len, n_req;

    always @(negedge clk) begin
        if (reset) begin
            prev_req = 0; prev_busy = 0; expect_fall = 0; have_prev = 0;
            low_cnt = 0; hi_len = 0;
        end else begin
            if (expect_fall) begin
                check("request_fall_after_completion", request, 0);
                expect_fall = 0;
            end
            if (request && !prev_req) begin
                n_req++;
                if (have_prev) check("gap_cycles", low_cnt, prev_we ? 2 : 3);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_request: addr 0x%0h we %0b, none expected", address, write_enable);
                end else begin
                    cur = exp_q.pop_front();
                    if ({write_enable, address, data_out} !== cur) begin
                        n_err++;
                        $display("FAIL txn: got we/addr/data 0x%0h expected 0x%0h",
                                 {write_enable, address, data_out}, cur);
                    end
                end
            end else if (request && prev_req) begin
                check("txn_stable", {write_enable, address, data_out}, cur);
            end
            if (request && prev_busy && !busy) expect_fall = 1;
            if (!request && prev_req) begin
                have_prev   = 1;
                prev_we     = cur[W-1];
                low_cnt     = 0;
                last_hi_len = hi_len;
                hi_len      = 0;
            end
            if (request) hi_len++;
            else low_cnt++;
            prev_req  = request;
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values();
        check("rst_request", request, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_code", fail_code, 0);
        check("rst_phase", phase, 0);
        check("rst_address", address, 0);
        check("rst_write_enable", write_enable, 0);
        check("rst_data_out", data_out, 0);
        check("rst_err_address", err_address, 0);
        check("rst_err_expected", err_expected, 0);
        check("rst_err_actual", err_actual, 0);
        check("rst_state", state_dbg, ST_IDLE);
    endtask

    task automatic pulse_start(input logic [15:0] lo, input logic [15:0] hi);
        @(negedge clk);
        have_prev = 0;
        addr_lo = lo; addr_hi = hi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_march(input logic [15:0] lo, input logic [15:0] hi, input bit h, input bit s);
        int  req0;
        bit  got;
        hang = h; stuck = s;
        build_model(lo, hi, h, s);
        req0 = n_req;
        pulse_start(lo, hi);
        if (lo > hi) begin
            check("range_done_next_cycle", done, 1);
            check("range_fail_code_next_cycle", fail_code, 2'd3);
        end else begin
            check("running_after_start", running, 1);
            check("done_cleared_by_start", done, 0);
        end
        got = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_err++;
            $display("FAIL run_done: done not seen for lo=0x%0h hi=0x%0h", lo, hi);
        end
        @(negedge clk);
        check("done", done, 1);
        check("pass", pass, exp_pass);
        check("fail_code", fail_code, exp_code);
        check("running_end", running, 0);
        check("request_end", request, 0);
        check("err_address", err_address, exp_err_a);
        check("err_expected", err_expected, exp_err_e);
        check("err_actual", err_actual, exp_err_x);
        check("transactions", n_req - req0, exp_txn);
        check("queue_drained", exp_q.size(), 0);
        if (lo <= hi) begin
            check("phase_end", phase, exp_phase);
            check("address_end", address, exp_addr);
        end
        hang = 0; stuck = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit got;
        reset = 1'b1; start = 1'b0; addr_lo = '0; addr_hi = '0;
        n_req = 0; last_hi_len = 0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Clean range: 16 transactions, pass.
        run_march(16'h0010, 16'h0013, 0, 0);
        check("clean_pass_literal", pass, 1);

        // Bit 3 stuck-at-1 at 0x0012: mismatch in phase 1.
        run_march(16'h0010, 16'h0013, 0, 1);
        check("stuck_code_literal", fail_code, 2'b01);
        check("stuck_err_address_literal", err_address, 16'h0012);
        check("stuck_err_expected_literal", err_expected, 16'hA5D1);
        check("stuck_err_actual_literal", err_actual, 16'hA5D9);
        check("stuck_phase_literal", phase, 2'd1);

        // Single top address: no wrap.
        run_march(16'hFFFF, 16'hFFFF, 0, 0);
        check("top_address_literal", address, 16'hFFFF);

        // Inverted range.
        run_march(16'h0005, 16'h0004, 0, 0);
        check("range_code_literal", fail_code, 2'b11);

        // Hung encoder: timeout after 1024 request-high cycles.
        run_march(16'h0020, 16'h0023, 1, 0);
        check("timeout_code_literal", fail_code, 2'b10);
        check("timeout_request_high_cycles", last_hi_len, 1024);

        // Reset in the middle of phase 2, then a clean run.
        build_model(16'h0010, 16'h0013, 0, 0);
        pulse_start(16'h0010, 16'h0013);
        got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (phase == 2'd2 && request) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_err++;
            $display("FAIL reach_phase2: phase 2 request not seen, phase=%0d", phase);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        run_march(16'h0010, 16'h0013, 0, 0);
        check("after_reset_pass_literal", pass, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
